// File: rtl/arb_request_ctrl.sv
// Requester-side controller for a round-robin arbiter: per-client burst credit counters,
// request generation and fixed-length bus ownership. Optional macro: ARB_GRANT_CHECK_EN.
module arb_request_ctrl #(
    parameter int request_lines = 4,
    parameter int burst_len     = 4,
    parameter int count_width   = 3,
    localparam int beat_width   = (burst_len > 1) ? $clog2(burst_len) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [request_lines-1:0] push,
    output logic [request_lines-1:0] full,
    output logic [request_lines-1:0] req,
    input  logic [request_lines-1:0] grant,
    output logic [request_lines-1:0] owner,
    output logic [beat_width-1:0]    beat,
    output logic                     last,
    output logic [request_lines-1:0] done,
    output logic                     grant_err
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    localparam logic [count_width-1:0] COUNT_MAX = '1;
    localparam logic [beat_width-1:0]  LAST_BEAT = beat_width'(burst_len - 1);

    state_t                   state;
    logic [count_width-1:0]   count [request_lines];
    logic [request_lines-1:0] pending;
    logic                     grant_onehot;
    logic                     grant_take;
    logic [beat_width-1:0]    beat_inc;

    always_comb begin
        pending = '0;
        full    = '0;
        for (int unsigned i = 0; i < request_lines; i++) begin
            pending[i] = (count[i] != '0);
            full[i]    = (count[i] == COUNT_MAX);
        end
    end

    assign req          = (state == IDLE) ? pending : '0;
    assign grant_onehot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
    assign grant_take   = (state == IDLE) && grant_onehot && ((grant & pending) != '0);
    assign beat_inc     = beat + 1'b1;

    // A done on a saturated line frees the slot that a same-cycle push then takes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < request_lines; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < request_lines; i++) begin
                case ({push[i] & (~full[i] | done[i]), done[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // last/done are registered, so they are loaded one beat ahead of the beat they mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            beat  <= '0;
            last  <= 1'b0;
            done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_take) begin
                        state <= OWN;
                        owner <= grant;
                        beat  <= '0;
                        last  <= (LAST_BEAT == '0);
                        done  <= (LAST_BEAT == '0) ? grant : '0;
                    end
                end
                OWN: begin
                    if (last) begin
                        state <= IDLE;
                        owner <= '0;
                        beat  <= '0;
                        last  <= 1'b0;
                        done  <= '0;
                    end else begin
                        beat  <= beat_inc;
                        last  <= (beat_inc == LAST_BEAT);
                        done  <= (beat_inc == LAST_BEAT) ? owner : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_GRANT_CHECK_EN
    logic [request_lines-1:0] req_q;
    logic                     err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            req_q <= req;
            if ((state == IDLE) &&
                (((grant != '0) && !grant_onehot) || ((grant & ~req_q) != '0))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign grant_err = err_q;
`else
    assign grant_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_request_ctrl.sv
// Scoreboard bench for arb_request_ctrl: queue-based pending-burst model, round-robin
// arbiter model, done monitor, plus a burst_len=1 instance.
module tb_arb_request_ctrl;

    localparam int NL   = 4;
    localparam int BL   = 4;
    localparam int CW   = 3;
    localparam int MAXC = 7;
    localparam int BW   = 2;
`ifdef ARB_GRANT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    push = '0, grant = '0;
    logic [3:0]    full, req, owner, done;
    logic [BW-1:0] beat;
    logic          last, grant_err;

    logic [3:0]    push1 = '0, grant1 = '0;
    logic [3:0]    full1, req1, owner1, done1;
    logic [0:0]    beat1;
    logic          last1, grant_err1;

    always #5 clk = ~clk;

    arb_request_ctrl #(.request_lines(NL), .burst_len(BL), .count_width(CW)) u_dut (
        .clk(clk), .rst(rst), .push(push), .full(full), .req(req), .grant(grant),
        .owner(owner), .beat(beat), .last(last), .done(done), .grant_err(grant_err)
    );

    arb_request_ctrl #(.request_lines(NL), .burst_len(1), .count_width(CW)) u_dut1 (
        .clk(clk), .rst(rst), .push(push1), .full(full1), .req(req1), .grant(grant1),
        .owner(owner1), .beat(beat1), .last(last1), .done(done1), .grant_err(grant_err1)
    );

    int nchk = 0, nfail = 0, cyc = 0;

    typedef struct {
        int client;
        int cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    // Reference model: pending bursts per client, current owner and burst start cycle.
    int         pend[NL];
    int         busy = -1;
    int         start_k = 0;
    bit         merr = 1'b0;
    logic [3:0] prev_req = '0;
    logic [3:0] arb_grant = '0;
    int         arb_ptr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NL; i++) if (busy < 0 && pend[i] > 0) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] m_full();
        logic [3:0] f;
        f = '0;
        for (int i = 0; i < NL; i++) if (pend[i] == MAXC) f[i] = 1'b1;
        return f;
    endfunction

    function automatic logic [3:0] m_owner();
        return (busy >= 0) ? 4'(1 << busy) : 4'd0;
    endfunction

    function automatic logic [BW-1:0] m_beat();
        return (busy >= 0) ? BW'(cyc - start_k) : '0;
    endfunction

    function automatic bit m_last();
        return (busy >= 0) && ((cyc - start_k) == BL - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) pend[i] = 0;
        busy = -1; merr = 1'b0; prev_req = '0; arb_grant = '0; arb_ptr = 0;
        exp_q.delete();
    endtask

    task automatic model_advance(input logic [3:0] p, input logic [3:0] g);
        logic [3:0] r;
        int dc, gi;
        bit cap;
        r   = m_req();
        dc  = m_last() ? busy : -1;
        cap = 1'b0;
        gi  = -1;
        if (busy < 0) begin
            if ($countones(g) == 1) begin
                for (int i = 0; i < NL; i++) if (g[i]) gi = i;
                if (pend[gi] > 0) cap = 1'b1;
            end
            if ((g != 0 && $countones(g) != 1) || ((g & ~prev_req) != 0)) merr = 1'b1;
        end
        for (int i = 0; i < NL; i++) begin
            if (p[i] && (pend[i] < MAXC || dc == i)) pend[i]++;
            if (dc == i) pend[i]--;
        end
        if (cap) begin
            busy    = gi;
            start_k = cyc + 1;
            exp_q.push_back('{client: gi, cyc: cyc + BL});
        end else if (dc >= 0) begin
            busy = -1;
        end
        prev_req = r;
    endtask

    task automatic check_outputs();
        chk("req", req, m_req());
        chk("full", full, m_full());
        chk("owner", owner, m_owner());
        chk("beat", beat, m_beat());
        chk("last", last, m_last());
        chk("grant_err", grant_err, CHK ? merr : 1'b0);
    endtask

    // One cycle: drive inputs, advance model and arbiter, then check the next cycle's outputs.
    task automatic step(input logic [3:0] p, input bit fz, input logic [3:0] gf);
        logic [3:0] g, r, nxt;
        int idx;
        g   = fz ? gf : arb_grant;
        r   = m_req();
        nxt = '0;
        if (r != 0) begin
            for (int j = 0; j < NL; j++) begin
                idx = (arb_ptr + j) % NL;
                if (r[idx] && nxt == 0) begin
                    nxt     = 4'(1 << idx);
                    arb_ptr = (idx + 1) % NL;
                end
            end
        end
        push  = p;
        grant = g;
        model_advance(p, g);
        arb_grant = nxt;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; push = '0; grant = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        check_outputs();
        chk("done_rst", done, 4'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                nchk++;
                nfail++;
                $display("FAIL done_missing cyc=%0d actual=0 required=%0h", cyc, 1 << exp_q[0].client);
                void'(exp_q.pop_front());
            end
            if (done != 0) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL done_unexpected cyc=%0d actual=%0h required=0", cyc, done);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_line", done, 1 << e.client);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // single burst on line 2
        step(4'b0100, 1'b0, '0);
        repeat (10) step('0, 1'b0, '0);

        // line 0 three times, line 3 once
        step(4'b1001, 1'b0, '0);
        step(4'b0001, 1'b0, '0);
        step(4'b0001, 1'b0, '0);
        repeat (40) step('0, 1'b0, '0);

        // saturate line 1 with grants held off; the 8th push is dropped
        repeat (8) step(4'b0010, 1'b1, '0);
        chk("full_after_fill", full, 4'b0010);
        repeat (60) step('0, 1'b0, '0);

        // non-one-hot grant in IDLE
        step(4'b0011, 1'b1, '0);
        step('0, 1'b1, '0);
        step('0, 1'b1, 4'b0011);
        step('0, 1'b1, 4'b0011);
        chk("owner_bad_grant", owner, 4'd0);
        repeat (20) step('0, 1'b0, '0);

        // asynchronous reset at beat 2
        step(4'b1000, 1'b0, '0);
        for (int i = 0; i < 12 && !(busy >= 0 && m_beat() == 2); i++) step('0, 1'b0, '0);
        chk("beat_before_rst", beat, 2);
        #1 rst = 1'b1;
        #1;
        chk("rst_owner", owner, 4'd0);
        chk("rst_beat", beat, 0);
        chk("rst_last", last, 0);
        chk("rst_done", done, 4'd0);
        chk("rst_req", req, 4'd0);
        chk("rst_full", full, 4'd0);
        chk("rst_grant_err", grant_err, 0);
        do_reset();
        repeat (5) step('0, 1'b0, '0);

        // randomized traffic, then drain
        repeat (300) step(4'($urandom) & 4'($urandom) & 4'($urandom), 1'b0, '0);
        repeat (300) step('0, 1'b0, '0);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("req_drained", req, 4'd0);

        // burst_len = 1 instance
        push1 = 4'b0001;
        @(posedge clk); #1;
        push1 = '0;
        chk("bl1_req", req1, 4'b0001);
        grant1 = 4'b0001;
        @(posedge clk); #1;
        grant1 = '0;
        chk("bl1_owner", owner1, 4'b0001);
        chk("bl1_beat", beat1, 0);
        chk("bl1_last", last1, 1);
        chk("bl1_done", done1, 4'b0001);
        @(posedge clk); #1;
        chk("bl1_owner_after", owner1, 4'd0);
        chk("bl1_last_after", last1, 0);
        chk("bl1_done_after", done1, 4'd0);
        chk("bl1_req_after", req1, 4'd0);
        chk("bl1_full", full1, 4'd0);
        chk("bl1_grant_err", grant_err1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/arb_request_ctrl.md
# arb_request_ctrl

Requester-side controller that sits opposite the round-robin arbiter. It queues burst requests from `request_lines` clients in per-client credit counters and drives the arbiter's `req` vector. It consumes the registered one-hot `grant` and holds shared-bus ownership for a fixed `burst_len` beats. It drops all requests during ownership, so the arbiter's registered grant releases cleanly between bursts.

## Interface
- `request_lines`, 4: number of clients; matches the arbiter's `request_lines`.
- `burst_len`, 4: beats per granted burst, ≥1.
- `count_width`, 3: per-client pending-burst counter width; max pending = 2^count_width − 1.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `push`  in  request_lines  per-client one-cycle pulse: enqueue one burst.
- `full`  out  request_lines  client counter saturated; a `push` on that line is dropped.
- `req`  out  request_lines  request vector to the arbiter.
- `grant`  in  request_lines  registered grant from the arbiter, expected one-hot or zero.
- `owner`  out  request_lines  one-hot current bus owner, zero when idle.
- `beat`  out  $clog2(burst_len) (min 1)  beat index within the burst.
- `last`  out  1  final beat of the burst.
- `done`  out  request_lines  one-cycle pulse on the owner's bit during the last beat.
- `grant_err`  out  1  sticky grant-protocol error; tied 0 unless configured.

## Operation
- Per-client `count[i]`:
  - `push[i] & ~full[i]` increments it.
  - `done[i]` decrements it.
  - Both in the same cycle: net unchanged.
  - `full[i] = (count[i] == 2^count_width−1)`.
- `req[i] = (count[i] != 0) & (state == IDLE)`, derived combinationally from registers.
- States:
  - IDLE: if `grant` is exactly one-hot and the granted line has `count != 0`, capture `owner <= grant`, `beat <= 0`, go to OWN. A zero grant, a non-one-hot grant, or a grant to a line with `count == 0` is ignored and the block stays in IDLE.
  - OWN: `beat` increments each cycle. `last = (beat == burst_len−1)`. `done = owner` while `last`. On the `last` cycle: go to IDLE, `owner <= 0`, `beat <= 0`.
- Grants arriving in OWN are ignored. This covers the stale grant in the first OWN cycle, caused by the arbiter's one-cycle grant register.
- `push` is accepted in every state, including for the current owner.
- The controller does not pick among clients itself; fairness comes entirely from the arbiter.

## Timing
- Reset values: `count` = 0, state IDLE, `owner` = 0, `beat` = 0, `last` = 0, `done` = 0, `req` = 0, `full` = 0, `grant_err` = 0.
- Reset is asynchronous and takes effect immediately, even mid-burst. The burst is abandoned, counts are cleared, and no `done` is emitted.
- Push-to-request: `push` in cycle t → `req` high in cycle t+1, if IDLE.
- Grant-to-ownership:
  - Grant sampled in IDLE at cycle t → `owner` valid in cycles t+1 .. t+burst_len.
  - `last` and `done` in cycle t+burst_len.
  - `req` reasserts in cycle t+burst_len+1; the next grant is visible in cycle t+burst_len+2.
- Minimum spacing between burst starts is burst_len+2 cycles.
- `burst_len` = 1: OWN lasts one cycle, in which `beat` = 0 and `last` = 1.
- A counter at max with simultaneous `push` and `done` stays at max; the `push` is accepted because `full` was high but `done` frees a slot. Rule: a push is accepted iff `~full | done[i]`.

## Configuration
- Macro: `ARB_GRANT_CHECK_EN`.
- Defined: in IDLE, `grant_err` is set on either of these, and stays set until `rst`:
  - `grant` is nonzero and not one-hot.
  - `grant[i]` = 1 while registered previous-cycle `req[i]` was 0.

  Capture behaviour is unchanged.
- Undefined: `grant_err` is constant 0 and no checker logic is built.

## Test plan
- Reset, `push[2]` once, model arbiter grants `grant = 4'b0100` one cycle after `req` → `owner = 4'b0100` for 4 cycles, `beat` 0..3, `done[2]` pulses with `last`, `count[2]` returns to 0, `req` = 0 afterwards.
- Push line 0 three times, line 3 once, with a round-robin arbiter model → the grant sequence yields 4 bursts total, each separated by ≥6 cycles, and every pushed burst gets exactly one `done`.
- Push line 1 eight times back-to-back with `count_width` = 3 → `full[1]` rises after the 7th accepted push, the 8th is dropped, and exactly 7 `done[1]` pulses follow.
- Drive `grant = 4'b0011` in IDLE → no ownership; `grant_err` = 1 with `ARB_GRANT_CHECK_EN`, 0 without.
- Assert `rst` at beat 2 of a burst → all outputs go to reset values immediately, no `done` is emitted, and `req` = 0 until a new `push`.
- `burst_len` = 1, with `push[0]` and a grant → `owner`, `last` and `done[0]` all high for one single cycle.
